// File: rtl/fp_addsub_seq_ctrl.sv
// Sequencing controller for a floating-point add/subtract datapath: compare, align,
// add, normalise, then hold the result until the consumer takes it.
module fp_addsub_seq_ctrl #(
    parameter int unsigned MAN_WIDTH = 23,
    parameter int unsigned MAX_ALIGN = MAN_WIDTH + 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       op_sub,
    input  logic [1:0] exp_disc,
    input  logic [4:0] shift_spaces,
    input  logic       sum_carry,
    input  logic       sum_msb,
    input  logic       sum_zero,
    output logic       ld_operands,
    output logic       swap,
    output logic       align_shift,
    output logic       add_en,
    output logic       sub_mode,
    output logic       carry_shift,
    output logic       norm_shift,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       zero_res,
    output logic       busy
);

    localparam int unsigned AlignW = $clog2(MAX_ALIGN + 2);
    localparam int unsigned NormW  = $clog2(MAN_WIDTH + 2);
    localparam logic [AlignW-1:0] AlignMax = AlignW'(MAX_ALIGN);
    localparam logic [AlignW-1:0] AlignOne = AlignW'(1);
    localparam logic [NormW-1:0]  NormMax  = NormW'(MAN_WIDTH);
    localparam logic [NormW-1:0]  NormOne  = NormW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StCmp,
        StAlign,
        StAdd,
        StNorm,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic              op_sub_r, op_sub_d;
    logic              swap_r, swap_d;
    logic [AlignW-1:0] align_cnt, align_cnt_d;
    logic [NormW-1:0]  norm_cnt, norm_cnt_d;
    logic              zero_res_r, zero_res_d;
    logic [AlignW-1:0] align_init;
    logic              accept;
    logic              norm_more;

    // in_ready is masked by rst so nothing can be accepted while reset is held
    assign in_ready    = (state_q == StIdle) & ~rst;
    assign accept      = in_valid & in_ready;
    assign ld_operands = accept;
    assign norm_more   = ~sum_msb & (norm_cnt < NormMax);

    // Differences beyond MAX_ALIGN flush the smaller operand; further shifts are wasted
    always_comb begin
        if (32'(shift_spaces) > MAX_ALIGN) begin
            align_init = AlignMax;
        end else begin
            align_init = AlignW'(shift_spaces);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_sub_r   <= 1'b0;
            swap_r     <= 1'b0;
            align_cnt  <= '0;
            norm_cnt   <= '0;
            zero_res_r <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_sub_r   <= op_sub_d;
            swap_r     <= swap_d;
            align_cnt  <= align_cnt_d;
            norm_cnt   <= norm_cnt_d;
            zero_res_r <= zero_res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_sub_d    = op_sub_r;
        swap_d      = swap_r;
        align_cnt_d = align_cnt;
        norm_cnt_d  = norm_cnt;
        zero_res_d  = zero_res_r;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_sub_d   = op_sub;
                    zero_res_d = 1'b0;
                    state_d    = StCmp;
                end
            end
            StCmp: begin
                // Illegal code 01 falls through as "equal": no swap
                swap_d      = (exp_disc == 2'b00);
                align_cnt_d = align_init;
                state_d     = (align_init != '0) ? StAlign : StAdd;
            end
            StAlign: begin
                align_cnt_d = align_cnt - AlignOne;
                if (align_cnt == AlignOne) begin
                    state_d = StAdd;
                end
            end
            StAdd: begin
                norm_cnt_d = '0;
                state_d    = StNorm;
            end
            StNorm: begin
                if (sum_zero) begin
                    zero_res_d = 1'b1;
                    state_d    = StDone;
                end else if (sum_carry) begin
                    state_d = StDone;
                end else if (norm_more) begin
                    norm_cnt_d = norm_cnt + NormOne;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        align_shift = 1'b0;
        add_en      = 1'b0;
        sub_mode    = 1'b0;
        carry_shift = 1'b0;
        norm_shift  = 1'b0;
        out_valid   = 1'b0;
        swap        = 1'b0;
        case (state_q)
            StAlign: begin
                align_shift = 1'b1;
                swap        = swap_r;
            end
            StAdd: begin
                add_en   = 1'b1;
                sub_mode = op_sub_r;
                swap     = swap_r;
            end
            StNorm: begin
                carry_shift = ~sum_zero & sum_carry;
                norm_shift  = ~sum_zero & ~sum_carry & norm_more;
                swap        = swap_r;
            end
            StDone: begin
                out_valid = 1'b1;
                swap      = swap_r;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign zero_res = zero_res_r;

endmodule

// File: tb/tb_fp_addsub_seq_ctrl.sv
// Bench for fp_addsub_seq_ctrl: a transaction-level model expands each operation into its
// expected per-cycle output pattern; a negedge process compares every cycle.
module tb_fp_addsub_seq_ctrl;

    localparam int MW = 23;
    localparam int MA = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       op_sub = 1'b0;
    logic [1:0] exp_disc = 2'b11;
    logic [4:0] shift_spaces = '0;
    logic       sum_carry = 1'b0;
    logic       sum_msb = 1'b0;
    logic       sum_zero = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, ld_operands, swap, align_shift, add_en, sub_mode;
    logic       carry_shift, norm_shift, out_valid, zero_res, busy;

    always #5 clk = ~clk;

    fp_addsub_seq_ctrl #(.MAN_WIDTH(MW), .MAX_ALIGN(MA)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .exp_disc(exp_disc), .shift_spaces(shift_spaces), .sum_carry(sum_carry),
        .sum_msb(sum_msb), .sum_zero(sum_zero), .ld_operands(ld_operands), .swap(swap),
        .align_shift(align_shift), .add_en(add_en), .sub_mode(sub_mode),
        .carry_shift(carry_shift), .norm_shift(norm_shift), .out_valid(out_valid),
        .out_ready(out_ready), .zero_res(zero_res), .busy(busy)
    );

    typedef struct packed {
        logic in_ready, ld_operands, swap, align_shift, add_en, sub_mode;
        logic carry_shift, norm_shift, out_valid, zero_res, busy;
    } outs_t;

    outs_t act, exp_cur;
    logic  chk_en = 1'b0;
    logic  zr_model = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;
    int    al_n = 0, nm_n = 0, cy_n = 0, ov_n = 0, lat = 0, lat_meas = -1;
    logic  lat_run = 1'b0;
    logic  zres_seen = 1'b0;

    assign act = {in_ready, ld_operands, swap, align_shift, add_en, sub_mode,
                  carry_shift, norm_shift, out_valid, zero_res, busy};

    function automatic void check(string name, int actv, int expv);
        n_checks++;
        if (actv == expv) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, actv, expv);
    endfunction

    // Per-cycle compare plus pulse/latency counters restarted on every accept
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (act === exp_cur) n_pass++;
            else $display("FAIL outputs t=%0t: got %b want %b", $time, act, exp_cur);
        end
        if (ld_operands) begin
            al_n <= 0; nm_n <= 0; cy_n <= 0; ov_n <= 0;
            lat <= 0; lat_run <= 1'b1; lat_meas <= -1; zres_seen <= 1'b0;
        end else begin
            al_n <= al_n + (align_shift ? 1 : 0);
            nm_n <= nm_n + (norm_shift ? 1 : 0);
            cy_n <= cy_n + (carry_shift ? 1 : 0);
            ov_n <= ov_n + (out_valid ? 1 : 0);
            if (out_valid) zres_seen <= zero_res;
            if (lat_run) begin
                if (out_valid) begin
                    lat_meas <= lat + 1;
                    lat_run  <= 1'b0;
                end else begin
                    lat <= lat + 1;
                end
            end
        end
    end

    outs_t q_exp[$];
    logic  q_msb[$];
    logic  q_ordy[$];
    logic  q_ival[$];

    function automatic outs_t base(logic by);
        outs_t e = '0;
        e.busy     = by;
        e.zero_res = zr_model;
        return e;
    endfunction

    function automatic void push(outs_t e, logic msb, logic ordy, logic iv);
        q_exp.push_back(e);
        q_msb.push_back(msb);
        q_ordy.push_back(ordy);
        q_ival.push_back(iv);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            out_ready = 1'b0;
            exp_cur = base(1'b0);
            exp_cur.in_ready = 1'b1;
            chk_en = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // Build the expected cycle pattern of one operation from its parameters, then drive it.
    // k = NORM cycles with sum_msb low before it rises; stop_after > 0 truncates the run.
    task automatic run_txn(input logic [1:0] disc, input int shift, input logic sub,
                           input logic carry, input logic zero, input int k,
                           input int wait_n, input int stop_after);
        outs_t e;
        int n, s, n_run;
        logic sw;
        n  = (shift > MA) ? MA : shift;
        sw = (disc == 2'b00);
        q_exp.delete(); q_msb.delete(); q_ordy.delete(); q_ival.delete();
        e = base(1'b0); e.in_ready = 1'b1; e.ld_operands = 1'b1;
        push(e, 1'b0, 1'b0, 1'b1);
        zr_model = 1'b0;
        push(base(1'b1), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            e = base(1'b1); e.swap = sw; e.align_shift = 1'b1;
            push(e, 1'b0, 1'b0, 1'b0);
        end
        e = base(1'b1); e.swap = sw; e.add_en = 1'b1; e.sub_mode = sub;
        push(e, 1'b0, 1'b0, 1'b0);
        if (zero) begin
            e = base(1'b1); e.swap = sw;
            push(e, 1'b0, 1'b0, 1'b0);
            zr_model = 1'b1;
        end else if (carry) begin
            e = base(1'b1); e.swap = sw; e.carry_shift = 1'b1;
            push(e, 1'b0, 1'b0, 1'b0);
        end else begin
            s = (k < MW) ? k : MW;
            for (int i = 0; i < s; i++) begin
                e = base(1'b1); e.swap = sw; e.norm_shift = 1'b1;
                push(e, 1'b0, 1'b0, 1'b0);
            end
            e = base(1'b1); e.swap = sw;
            push(e, (k < MW), 1'b0, 1'b0);
        end
        for (int i = 0; i <= wait_n; i++) begin
            e = base(1'b1); e.swap = sw; e.out_valid = 1'b1;
            push(e, 1'b1, (i == wait_n), 1'b1);
        end
        exp_disc = disc; shift_spaces = 5'(shift); op_sub = sub;
        sum_carry = carry; sum_zero = zero;
        n_run = (stop_after > 0) ? stop_after : q_exp.size();
        for (int i = 0; i < n_run; i++) begin
            in_valid = q_ival[i];
            sum_msb = q_msb[i];
            out_ready = q_ordy[i];
            exp_cur = q_exp[i];
            chk_en = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    int al_snap;

    initial begin
        exp_cur = '0;
        #1;
        check("reset_outputs", int'(act), 0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        run_txn(2'b11, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("t1_latency", lat_meas, 4);
        check("t1_align", al_n, 0);
        check("t1_norm", nm_n, 0);

        run_txn(2'b00, 5, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        check("t2_align", al_n, 5);
        check("t2_latency", lat_meas, 9);

        run_txn(2'b10, 31, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("t3_align_clip", al_n, 25);

        run_txn(2'b11, 0, 1'b0, 1'b0, 1'b0, 3, 0, 0);
        check("t4_norm", nm_n, 3);
        check("t4_latency", lat_meas, 7);

        run_txn(2'b11, 0, 1'b1, 1'b0, 1'b0, 40, 0, 0);
        check("t5_norm_stuck", nm_n, 23);
        check("t5_latency", lat_meas, 27);

        run_txn(2'b10, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        check("t6_carry", cy_n, 1);
        check("t6_latency", lat_meas, 4);

        run_txn(2'b11, 0, 1'b1, 1'b1, 1'b1, 0, 0, 0);
        check("t7_carry_suppressed", cy_n, 0);
        check("t7_zero_res", int'(zres_seen), 1);

        run_txn(2'b11, 0, 1'b0, 1'b0, 1'b0, 0, 3, 0);
        check("t8_out_valid_hold", ov_n, 4);
        check("t8_latency", lat_meas, 4);

        run_txn(2'b01, 2, 1'b0, 1'b0, 1'b0, 1, 0, 0);
        check("t9_align", al_n, 2);
        idle(2);

        // Reset while two ALIGN pulses have been issued and eight remain
        run_txn(2'b00, 10, 1'b0, 1'b0, 1'b0, 0, 0, 4);
        al_snap = al_n;
        rst = 1'b1;
        #1;
        check("rst_mid_align", int'(act), 0);
        zr_model = 1'b0;
        in_valid = 1'b1;
        exp_cur = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        idle(4);
        check("no_align_after_rst", al_n - al_snap, 0);

        run_txn(2'b11, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("post_rst_latency", lat_meas, 4);
        idle(1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
